bus_debug_display: RTL and testbench

// Parametrised board-level debug viewer for the bus system: takes NUM_CH packed probe words
// (controller/master/slave/arbiter states, read data), lets the user step through channels with

---
 rtl/bus_debug_pkg.sv | 36 +++
 rtl/key_debounce.sv | 56 +++++
 rtl/bus_debug_display.sv | 157 +++++++++++++++
 tb/tb_bus_debug_display.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_debug_pkg.sv
// Shared definitions for the bus debug display: blank glyph, hex glyph decoder
// and the channel step direction used by the channel counter.
package bus_debug_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_NEXT = 2'd1,
    STEP_PREV = 2'd2
  } step_e;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: synchronises an active-low raw key, accepts a new
// level only after it has been stable for DEBOUNCE_CYC cycles, and emits a
// single-cycle pulse when a press (high to low) is accepted.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             accept;

  // Count consecutive cycles the synced key disagrees with the accepted level; any bounce clears it.
  always_comb begin
    accept   = 1'b0;
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        accept   = 1'b1;
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser and debounce state; released (high) is the idle level out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= key_n;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press_pulse = accept & ~sync2_q;

endmodule

// File: rtl/bus_debug_display.sv
// Board-level debug viewer: steps through NUM_CH probe words with debounced
// keys or auto-scroll, can freeze a snapshot, and drives active-low hex digits
// through a two-stage (select, decode) display pipeline.
module bus_debug_display
  import bus_debug_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CH_W         = 8,
  parameter int NUM_DIGITS   = 2,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int SCROLL_CYC   = 50000000,
  parameter int BLANK_LZ     = 0,
  localparam int CH_IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*CH_W-1:0]  probe_bus,
  input  logic                    key_next,
  input  logic                    key_prev,
  input  logic                    auto_en,
  input  logic                    freeze,
  output logic [7*NUM_DIGITS-1:0] hex_seg,
  output logic [CH_IDX_W-1:0]     ch_sel,
  output logic                    frozen
);

  localparam int DISP_W = NUM_DIGITS * 4;
  localparam int COPY_W = (CH_W < DISP_W) ? CH_W : DISP_W;
  localparam int SCR_W  = (SCROLL_CYC > 1) ? $clog2(SCROLL_CYC) : 1;
  localparam logic [SCR_W-1:0]    SCR_LAST = SCR_W'(SCROLL_CYC - 1);
  localparam logic [CH_IDX_W-1:0] CH_LAST  = CH_IDX_W'(NUM_CH - 1);

  logic                    next_pulse;
  logic                    prev_pulse;
  logic                    auto_s1_q;
  logic                    auto_s2_q;
  logic                    frz_s1_q;
  logic                    frz_s2_q;
  logic                    frozen_q;
  logic                    frozen_d;
  logic [NUM_CH*CH_W-1:0]  snap_q;
  logic [NUM_CH*CH_W-1:0]  snap_d;
  logic [SCR_W-1:0]        scroll_q;
  logic [SCR_W-1:0]        scroll_d;
  logic                    scroll_expire;
  logic [CH_IDX_W-1:0]     ch_q;
  logic [CH_IDX_W-1:0]     ch_d;
  step_e                   step;
  logic [NUM_CH*CH_W-1:0]  src;
  logic [CH_W-1:0]         sel;
  logic [DISP_W-1:0]       word_q;
  logic [DISP_W-1:0]       word_d;
  logic [7*NUM_DIGITS-1:0] seg_q;
  logic [7*NUM_DIGITS-1:0] seg_d;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_next (
    .clk         (clk),
    .reset       (reset),
    .key_n       (key_next),
    .press_pulse (next_pulse)
  );

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_prev (
    .clk         (clk),
    .reset       (reset),
    .key_n       (key_prev),
    .press_pulse (prev_pulse)
  );

  // Scroll timer and channel step: a key pulse restarts the timer and beats a same-cycle expiry.
  always_comb begin
    scroll_d      = '0;
    scroll_expire = 1'b0;
    if (auto_s2_q && !(next_pulse || prev_pulse)) begin
      if (scroll_q == SCR_LAST) begin
        scroll_expire = 1'b1;
      end else begin
        scroll_d = scroll_q + 1'b1;
      end
    end
    step = STEP_NONE;
    if (next_pulse && !prev_pulse) begin
      step = STEP_NEXT;
    end else if (prev_pulse && !next_pulse) begin
      step = STEP_PREV;
    end else if (scroll_expire) begin
      step = STEP_NEXT;
    end
    case (step)
      STEP_NEXT: ch_d = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
      STEP_PREV: ch_d = (ch_q == '0) ? CH_LAST : ch_q - 1'b1;
      default:   ch_d = ch_q;
    endcase
  end

  // Capture every channel on the rising edge of the synced freeze level.
  always_comb begin
    frozen_d = frz_s2_q;
    snap_d   = (frz_s2_q && !frozen_q) ? probe_bus : snap_q;
  end

  // Pipeline stage 1 input: pick the displayed channel from live or snapshot data.
  always_comb begin
    src = frozen_q ? snap_q : probe_bus;
    sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_q == CH_IDX_W'(k)) begin
        sel = src[k*CH_W +: CH_W];
      end
    end
    word_d = '0;
    word_d[COPY_W-1:0] = sel[COPY_W-1:0];
  end

  // Pipeline stage 2 input: decode each nibble, optionally blanking leading zero digits.
  always_comb begin
    seg_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      seg_d[7*i +: 7] = hex_to_seg(word_q[4*i +: 4]);
      if ((BLANK_LZ != 0) && (i > 0) && ((word_q >> (4*i)) == '0)) begin
        seg_d[7*i +: 7] = SEG_BLANK;
      end
    end
  end

  // All top-level state: level synchronisers, channel, scroll timer, snapshot and display pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      auto_s1_q <= 1'b0;
      auto_s2_q <= 1'b0;
      frz_s1_q  <= 1'b0;
      frz_s2_q  <= 1'b0;
      frozen_q  <= 1'b0;
      snap_q    <= '0;
      scroll_q  <= '0;
      ch_q      <= '0;
      word_q    <= '0;
      seg_q     <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      auto_s1_q <= auto_en;
      auto_s2_q <= auto_s1_q;
      frz_s1_q  <= freeze;
      frz_s2_q  <= frz_s1_q;
      frozen_q  <= frozen_d;
      snap_q    <= snap_d;
      scroll_q  <= scroll_d;
      ch_q      <= ch_d;
      word_q    <= word_d;
      seg_q     <= seg_d;
    end
  end

  assign hex_seg = seg_q;
  assign ch_sel  = ch_q;
  assign frozen  = frozen_q;

endmodule

// File: tb/tb_bus_debug_display.sv
// Self-checking bench for bus_debug_display: two instances (plain and
// leading-zero blanking) share one set of inputs; expectations come from a
// behavioural model of channel position, snapshot contents and hex glyphs.
module tb_bus_debug_display;

   localparam int NumCh     = 3;
   localparam int ChW       = 8;
   localparam int DebCyc    = 4;
   localparam int ScrollCyc = 10;
   localparam int PressLat  = 2 + DebCyc;

   logic        clk;
   logic        reset;
   logic [7:0]  live [3];
   logic [23:0] probeBus;
   logic        keyNext;
   logic        keyPrev;
   logic        autoEn;
   logic        freeze;
   logic [13:0] hexPlain;
   logic [13:0] hexLz;
   logic [1:0]  chPlain;
   logic [1:0]  chLz;
   logic        frozenPlain;
   logic        frozenLz;

   int          vectors = 0;
   int          miscompares = 0;
   int          expCh = 0;
   bit          frozenModel = 1'b0;
   logic [7:0]  snap [3];
   bit          changed;

   // Active-high gfedcba patterns of the standard hex glyphs (b, d lower case).
   logic [6:0]  glyphOn [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   assign probeBus = {live[2], live[1], live[0]};

   bus_debug_display #(
      .NUM_CH(NumCh), .CH_W(ChW), .NUM_DIGITS(2),
      .DEBOUNCE_CYC(DebCyc), .SCROLL_CYC(ScrollCyc), .BLANK_LZ(0)
   ) dut (
      .clk(clk), .reset(reset), .probe_bus(probeBus),
      .key_next(keyNext), .key_prev(keyPrev), .auto_en(autoEn), .freeze(freeze),
      .hex_seg(hexPlain), .ch_sel(chPlain), .frozen(frozenPlain)
   );

   bus_debug_display #(
      .NUM_CH(NumCh), .CH_W(ChW), .NUM_DIGITS(2),
      .DEBOUNCE_CYC(DebCyc), .SCROLL_CYC(ScrollCyc), .BLANK_LZ(1)
   ) dutLz (
      .clk(clk), .reset(reset), .probe_bus(probeBus),
      .key_next(keyNext), .key_prev(keyPrev), .auto_en(autoEn), .freeze(freeze),
      .hex_seg(hexLz), .ch_sel(chLz), .frozen(frozenLz)
   );

   // Free-running 100 MHz-style clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [13:0] expSeg(input logic [7:0] word, input bit lz);
      logic [13:0] r;
      int v;
      int d;
      r = '0;
      v = int'(word);
      for (int i = 0; i < 2; i++) begin
         d = (v >> (4*i)) % 16;
         r[7*i +: 7] = ~glyphOn[d];
         if (lz && i > 0 && (v >> (4*i)) == 0) r[7*i +: 7] = 7'h7F;
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkDisplay(input string tag);
      logic [7:0] w;
      w = frozenModel ? snap[expCh] : live[expCh];
      checkOutput({tag, "_chPlain"}, 32'(chPlain), 32'(expCh));
      checkOutput({tag, "_chLz"}, 32'(chLz), 32'(expCh));
      checkOutput({tag, "_hexPlain"}, 32'(hexPlain), 32'(expSeg(w, 1'b0)));
      checkOutput({tag, "_hexLz"}, 32'(hexLz), 32'(expSeg(w, 1'b1)));
      checkOutput({tag, "_frozen"}, 32'(frozenPlain), 32'(frozenModel));
   endtask

   // kind: 0 next, 1 prev, 2 both together, 3 short bounce on next
   task automatic applyStimulus(input int kind, input int hold);
      if (kind == 0 || kind == 2 || kind == 3) keyNext = 1'b0;
      if (kind == 1 || kind == 2) keyPrev = 1'b0;
      repeat (hold) tick();
      keyNext = 1'b1;
      keyPrev = 1'b1;
      repeat (8) tick();
      if (kind == 0) expCh = (expCh + 1) % NumCh;
      else if (kind == 1) expCh = (expCh + NumCh - 1) % NumCh;
   endtask

   task automatic pressExact(input string tag, input bit isNext);
      int newCh;
      logic [7:0] oldWord;
      logic [7:0] newWord;
      newCh   = isNext ? (expCh + 1) % NumCh : (expCh + NumCh - 1) % NumCh;
      oldWord = live[expCh];
      newWord = live[newCh];
      if (isNext) keyNext = 1'b0;
      else keyPrev = 1'b0;
      for (int i = 1; i <= PressLat; i++) begin
         tick();
         checkOutput({tag, "_chStep"}, 32'(chPlain), 32'((i < PressLat) ? expCh : newCh));
      end
      expCh = newCh;
      checkOutput({tag, "_hexLag0"}, 32'(hexPlain), 32'(expSeg(oldWord, 1'b0)));
      tick();
      checkOutput({tag, "_hexLag1"}, 32'(hexPlain), 32'(expSeg(oldWord, 1'b0)));
      tick();
      checkOutput({tag, "_hexLag2"}, 32'(hexPlain), 32'(expSeg(newWord, 1'b0)));
      repeat (4) tick();
      checkOutput({tag, "_noRepeat"}, 32'(chPlain), 32'(expCh));
      keyNext = 1'b1;
      keyPrev = 1'b1;
      repeat (8) tick();
      checkDisplay(tag);
   endtask

   initial begin
      reset   = 1'b0;
      keyNext = 1'b1;
      keyPrev = 1'b1;
      autoEn  = 1'b0;
      freeze  = 1'b0;
      live[0] = 8'h3A;
      live[1] = 8'($urandom);
      live[2] = 8'($urandom);
      while (live[1] == live[0]) live[1] = 8'($urandom);
      while (live[2] == live[0] || live[2] == live[1]) live[2] = 8'($urandom);
      for (int k = 0; k < NumCh; k++) snap[k] = '0;

      repeat (3) tick();
      checkOutput("reset_hexPlain", 32'(hexPlain), 32'(14'h3FFF));
      checkOutput("reset_hexLz", 32'(hexLz), 32'(14'h3FFF));
      checkOutput("reset_ch", 32'(chPlain), 32'(0));
      checkOutput("reset_frozen", 32'(frozenPlain), 32'(0));

      reset = 1'b1;
      repeat (2) tick();
      checkOutput("ch0_3A_glyphs", 32'(hexPlain), 32'({7'h30, 7'h08}));
      checkDisplay("after_reset");

      // Short bounce must not register.
      keyNext = 1'b0;
      repeat (2) tick();
      keyNext = 1'b1;
      repeat (8) tick();
      checkDisplay("bounce");

      pressExact("next_0to1", 1'b1);
      pressExact("prev_1to0", 1'b0);
      pressExact("prev_wrap", 1'b0);
      checkOutput("prev_wrap_is2", 32'(chPlain), 32'(2));
      pressExact("next_a", 1'b1);
      pressExact("next_b", 1'b1);
      pressExact("next_c", 1'b1);

      // Live probe change reaches the digits exactly two cycles later.
      begin
         logic [7:0] oldW;
         logic [7:0] newW;
         oldW = live[expCh];
         newW = oldW + 8'(1 + $urandom_range(0, 254));
         live[expCh] = newW;
         tick();
         checkOutput("live_lag1", 32'(hexPlain), 32'(expSeg(oldW, 1'b0)));
         tick();
         checkOutput("live_lag2", 32'(hexPlain), 32'(expSeg(newW, 1'b0)));
      end

      // Randomised probe data and key activity.
      for (int n = 0; n < 20; n++) begin
         int kind;
         for (int k = 0; k < NumCh; k++) live[k] = 8'($urandom);
         kind = int'($urandom_range(0, 3));
         applyStimulus(kind, (kind == 3) ? int'($urandom_range(1, 3)) : int'($urandom_range(6, 10)));
         checkDisplay("random");
      end

      // Freeze a snapshot on channel 1.
      for (int n = 0; n < 3 && expCh != 1; n++) applyStimulus(0, 6);
      live[1] = 8'h55;
      repeat (3) tick();
      freeze = 1'b1;
      repeat (2) tick();
      checkOutput("freeze_rise_early", 32'(frozenPlain), 32'(0));
      tick();
      checkOutput("freeze_rise", 32'(frozenPlain), 32'(1));
      for (int k = 0; k < NumCh; k++) snap[k] = live[k];
      frozenModel = 1'b1;
      live[1] = 8'hAA;
      live[0] = 8'($urandom);
      live[2] = 8'($urandom);
      repeat (4) tick();
      checkOutput("frozen_55", 32'(hexPlain), 32'({7'h12, 7'h12}));
      checkDisplay("frozen_ch1");
      applyStimulus(0, 7);
      checkDisplay("frozen_ch2");
      applyStimulus(1, 7);
      checkDisplay("frozen_back_ch1");
      freeze = 1'b0;
      repeat (2) tick();
      checkOutput("freeze_fall_early", 32'(frozenPlain), 32'(1));
      tick();
      checkOutput("freeze_fall", 32'(frozenPlain), 32'(0));
      checkOutput("unfreeze_lag0", 32'(hexPlain), 32'({7'h12, 7'h12}));
      tick();
      checkOutput("unfreeze_lag1", 32'(hexPlain), 32'({7'h12, 7'h12}));
      tick();
      checkOutput("unfreeze_AA", 32'(hexPlain), 32'({7'h08, 7'h08}));
      frozenModel = 1'b0;
      checkDisplay("unfrozen");

      // Auto-scroll period and restart on a key press.
      autoEn = 1'b1;
      changed = 1'b0;
      for (int i = 0; i < 3 * ScrollCyc && !changed; i++) begin
         tick();
         if (chPlain != 2'(expCh)) changed = 1'b1;
      end
      checkOutput("auto_first_step", 32'(changed), 32'(1));
      expCh = (expCh + 1) % NumCh;
      checkOutput("auto_first_ch", 32'(chPlain), 32'(expCh));
      for (int r = 0; r < 2; r++) begin
         for (int i = 1; i <= ScrollCyc; i++) begin
            tick();
            checkOutput("auto_period", 32'(chPlain),
                        32'((i < ScrollCyc) ? expCh : (expCh + 1) % NumCh));
         end
         expCh = (expCh + 1) % NumCh;
      end
      keyNext = 1'b0;
      for (int i = 1; i <= PressLat; i++) begin
         tick();
         checkOutput("auto_key", 32'(chPlain),
                     32'((i < PressLat) ? expCh : (expCh + 1) % NumCh));
      end
      expCh = (expCh + 1) % NumCh;
      keyNext = 1'b1;
      for (int i = 1; i <= ScrollCyc; i++) begin
         tick();
         checkOutput("auto_after_key", 32'(chPlain),
                     32'((i < ScrollCyc) ? expCh : (expCh + 1) % NumCh));
      end
      expCh = (expCh + 1) % NumCh;
      autoEn = 1'b0;
      repeat (2 * ScrollCyc) tick();
      checkDisplay("auto_off");

      // Leading-zero blanking on channel 0.
      for (int n = 0; n < 3 && expCh != 0; n++) applyStimulus(0, 6);
      live[0] = 8'h07;
      repeat (3) tick();
      checkOutput("lz_07", 32'(hexLz), 32'({7'h7F, 7'h78}));
      checkOutput("plain_07", 32'(hexPlain), 32'({7'h40, 7'h78}));
      live[0] = 8'h00;
      repeat (3) tick();
      checkOutput("lz_00", 32'(hexLz), 32'({7'h7F, 7'h40}));
      live[0] = 8'h70;
      repeat (3) tick();
      checkOutput("lz_70", 32'(hexLz), 32'({7'h78, 7'h40}));
      checkDisplay("lz_done");

      // Reset in the middle of a debounce, key held through reset release.
      applyStimulus(0, 6);
      keyNext = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      #1;
      checkOutput("midreset_hex", 32'(hexPlain), 32'(14'h3FFF));
      checkOutput("midreset_ch", 32'(chPlain), 32'(0));
      checkOutput("midreset_frozen", 32'(frozenPlain), 32'(0));
      expCh = 0;
      repeat (2) tick();
      reset = 1'b1;
      for (int i = 1; i <= PressLat; i++) begin
         tick();
         checkOutput("held_through_reset", 32'(chPlain), 32'((i < PressLat) ? 0 : 1));
      end
      expCh = 1;
      repeat (6) tick();
      keyNext = 1'b1;
      repeat (8) tick();
      checkDisplay("after_midreset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
